// File: rtl/periph_reg_bank_interface_if.sv
// Arilla bus view seen by a register window: host request fields in,
// hit and read data returned on shared (tri-stated) lines.
interface arilla_bus_if #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32
);
    logic [AddrWidth-1:0]   address;
    logic [DataWidth/8-1:0] byte_enable;
    logic [DataWidth-1:0]   data_ctp;
    logic                   read;
    logic                   write;
    logic                   intercept;

    logic                   hit_oe;
    logic                   data_ptc_oe;
    logic [DataWidth-1:0]   data_ptc_drv;

    // Several windows share these lines; only the claiming one drives them.
    wire                    hit;
    wire  [DataWidth-1:0]   data_ptc;

    assign hit      = hit_oe ? 1'b1 : 1'bz;
    assign data_ptc = data_ptc_oe ? data_ptc_drv : 'z;

    modport periph (
        input  address, byte_enable, data_ctp, read, write, intercept,
        output hit_oe, data_ptc_oe, data_ptc_drv
    );

    modport host (
        output address, byte_enable, data_ctp, read, write, intercept,
        input  hit, data_ptc, hit_oe, data_ptc_oe
    );
endinterface

// File: rtl/periph_reg_bank_interface.sv
// Memory-mapped register window: decodes a SizeWords-word region, produces
// byte-merged write data with RW/RO/W1C modes, and returns reads after ReadLatency.
module periph_reg_bank_interface #(
    parameter int unsigned          AddrWidth   = 32,
    parameter int unsigned          DataWidth   = 32,
    parameter int unsigned          BaseAddress = 32'h0000_1000,
    parameter int unsigned          SizeWords   = 4,
    parameter int unsigned          ReadLatency = 1,
    parameter logic [SizeWords-1:0] RoMask      = '0,
    parameter logic [SizeWords-1:0] W1cMask     = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    arilla_bus_if.periph                   bus_interface,
    input  logic [SizeWords*DataWidth-1:0] data_periph_in,
    output logic [DataWidth-1:0]           data_periph_out,
    output logic [SizeWords-1:0]           data_periph_write,
    output logic [SizeWords-1:0]           data_periph_read,
    output logic                           ro_write_err
);
    localparam int unsigned BytesPerWord = DataWidth / 8;
    localparam int unsigned Law          = $clog2(SizeWords);
    localparam int unsigned Lbpw         = $clog2(BytesPerWord);
    // Bus addresses are word addresses; the base is given in bytes.
    localparam logic [AddrWidth-1:0] BaseWord = AddrWidth'(BaseAddress >> Lbpw);

    logic                 hit;
    logic [Law-1:0]       idx;
    logic [DataWidth-1:0] cur;
    logic [DataWidth-1:0] mask;
    logic [DataWidth-1:0] wdata;

    logic [ReadLatency:1] rd_valid;
    logic [DataWidth-1:0] rd_data [1:ReadLatency];

    assign hit = bus_interface.address[AddrWidth-1:Law] == BaseWord[AddrWidth-1:Law];
    assign idx = bus_interface.address[Law-1:0];

    always_comb begin
        cur = '0;
        for (int i = 0; i < SizeWords; i++) begin
            if (idx == Law'(i)) begin
                cur = data_periph_in[i*DataWidth +: DataWidth];
            end
        end
    end

    always_comb begin
        mask = '0;
        for (int b = 0; b < BytesPerWord; b++) begin
            mask[b*8 +: 8] = {8{bus_interface.byte_enable[b]}};
        end
    end

    assign wdata = bus_interface.data_ctp & mask;

    always_comb begin
        if (RoMask[idx]) begin
            data_periph_out = cur;
        end else if (W1cMask[idx]) begin
            data_periph_out = cur & ~wdata;
        end else begin
            data_periph_out = wdata | (cur & ~mask);
        end
    end

    always_comb begin
        data_periph_write = '0;
        data_periph_read  = '0;
        if (hit && bus_interface.write && !RoMask[idx] && !rst) begin
            data_periph_write[idx] = 1'b1;
        end
        if (hit && bus_interface.read && !rst) begin
            data_periph_read[idx] = 1'b1;
        end
    end

    // Stage 1 captures the pre-write word, so a same-cycle write never leaks into the read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid     <= '0;
            ro_write_err <= 1'b0;
            for (int i = 1; i <= ReadLatency; i++) begin
                rd_data[i] <= '0;
            end
        end else begin
            rd_valid[1]  <= hit & bus_interface.read;
            rd_data[1]   <= cur;
            ro_write_err <= hit & bus_interface.write & RoMask[idx];
            for (int i = 2; i <= ReadLatency; i++) begin
                rd_valid[i] <= rd_valid[i-1];
                rd_data[i]  <= rd_data[i-1];
            end
        end
    end

    assign bus_interface.hit_oe       = hit;
    assign bus_interface.data_ptc_oe  = rd_valid[ReadLatency] & ~bus_interface.intercept;
    assign bus_interface.data_ptc_drv = rd_data[ReadLatency];
endmodule

// File: tb/tb_periph_reg_bank_interface.sv
// Scoreboard bench for the register window: directed cases then random traffic
// against an array-based register model.
module tb_periph_reg_bank_interface;
    localparam int             SW   = 4;
    localparam int             DW   = 32;
    localparam int             AW   = 32;
    localparam int             RL   = 3;
    localparam int             BASE = 32'h0000_1000;
    localparam logic [SW-1:0]  RO   = 4'b0001;
    localparam logic [SW-1:0]  W1C  = 4'b0100;
    localparam logic [31:0]    WB   = 32'h0000_0400;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    arilla_bus_if #(.AddrWidth(AW), .DataWidth(DW)) bus ();

    logic [SW*DW-1:0] data_periph_in;
    logic [DW-1:0]    data_periph_out;
    logic [SW-1:0]    data_periph_write;
    logic [SW-1:0]    data_periph_read;
    logic             ro_write_err;

    periph_reg_bank_interface #(
        .AddrWidth(AW), .DataWidth(DW), .BaseAddress(BASE), .SizeWords(SW),
        .ReadLatency(RL), .RoMask(RO), .W1cMask(W1C)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .bus_interface    (bus),
        .data_periph_in   (data_periph_in),
        .data_periph_out  (data_periph_out),
        .data_periph_write(data_periph_write),
        .data_periph_read (data_periph_read),
        .ro_write_err     (ro_write_err)
    );

    typedef struct {
        int          due;
        logic [31:0] data;
    } rd_t;

    rd_t         sb [$];
    logic [31:0] mem [SW];
    int          tests   = 0;
    int          fails   = 0;
    int          cyc     = 0;
    bit          running = 1'b0;
    logic        exp_err = 1'b0;
    logic        m_ev;
    logic [31:0] m_ed;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] model_write(input int idx, input logic [31:0] d,
                                                input logic [3:0] be, input logic [31:0] cur);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 4; b++) if (be[b]) m[8*b +: 8] = 8'hFF;
        if (RO[idx])  return cur;
        if (W1C[idx]) return cur & ~(d & m);
        return (d & m) | (cur & ~m);
    endfunction

    task automatic cycle(input logic r, input logic [31:0] a, input logic rd, input logic wr,
                         input logic [3:0] be, input logic [31:0] d, input logic icpt,
                         input logic chk_want, input logic [31:0] want);
        logic        inwin;
        int          idx;
        logic [31:0] cur, eo;
        logic [3:0]  ew, er;
        @(negedge clk);
        rst = r;
        bus.address = a; bus.read = rd; bus.write = wr;
        bus.byte_enable = be; bus.data_ctp = d; bus.intercept = icpt;
        for (int i = 0; i < SW; i++) data_periph_in[i*DW +: DW] = mem[i];
        #1;
        inwin = (a / SW) == ((BASE / 4) / SW);
        idx   = int'(a % SW);
        cur   = mem[idx];
        eo    = model_write(idx, d, be, cur);
        ew    = (inwin && wr && !r && !RO[idx]) ? 4'(1 << idx) : 4'b0;
        er    = (inwin && rd && !r) ? 4'(1 << idx) : 4'b0;
        check("hit", 32'(bus.hit_oe), 32'(inwin));
        check("wr_strobe", 32'(data_periph_write), 32'(ew));
        check("rd_strobe", 32'(data_periph_read), 32'(er));
        if (inwin && wr) check("wdata", data_periph_out, eo);
        if (chk_want) check("directed_wdata", data_periph_out, want);
        @(posedge clk);
        if (r) begin
            sb.delete();
            exp_err = 1'b0;
        end else begin
            if (inwin && rd) sb.push_back('{cyc + RL, cur});
            exp_err = inwin && wr && RO[idx];
        end
        if (ew != 4'b0) mem[idx] = eo;
        cyc++;
    endtask

    task automatic idle(input int n, input logic icpt);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, icpt, 1'b0, 32'h0);
    endtask

    always @(negedge clk) begin
        #3;
        if (running) begin
            m_ev = 1'b0;
            m_ed = '0;
            if (sb.size() > 0 && sb[0].due == cyc) begin
                m_ev = 1'b1;
                m_ed = sb[0].data;
                void'(sb.pop_front());
            end
            check("ptc_drive", 32'(bus.data_ptc_oe), 32'(m_ev && !bus.intercept));
            if (m_ev && !bus.intercept) check("ptc_data", bus.data_ptc, m_ed);
            check("ro_err", 32'(ro_write_err), 32'(exp_err));
        end
    end

    initial begin
        mem[0] = 32'hAAAA_0000;
        mem[1] = 32'h1122_3344;
        mem[2] = 32'h0000_00F5;
        mem[3] = 32'h5A5A_5A5A;
        rst = 1'b1;
        bus.address = '0; bus.read = 1'b0; bus.write = 1'b0;
        bus.byte_enable = '0; bus.data_ctp = '0; bus.intercept = 1'b0;
        data_periph_in = '0;
        cycle(1'b1, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        running = 1'b1;
        cycle(1'b1, WB, 1'b1, 1'b1, 4'hF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);
        idle(1, 1'b0);

        cycle(1'b0, WB + 1, 1'b0, 1'b1, 4'b0011, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h1122_BEEF);
        cycle(1'b0, WB + 2, 1'b0, 1'b1, 4'b0001, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_00F0);
        cycle(1'b0, WB + 0, 1'b0, 1'b1, 4'hF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'hAAAA_0000);
        idle(2, 1'b0);

        for (int i = 0; i < SW; i++)
            cycle(1'b0, WB + i, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        idle(RL + 1, 1'b0);

        cycle(1'b0, WB + 1, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        idle(RL + 1, 1'b0);

        cycle(1'b0, WB + 1, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        idle(RL - 1, 1'b0);
        idle(1, 1'b1);
        cycle(1'b0, WB + 3, 1'b1, 1'b1, 4'hF, 32'h1234_5678, 1'b0, 1'b1, 32'h1234_5678);
        cycle(1'b0, 32'h0000_0999, 1'b1, 1'b1, 4'hF, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0);
        idle(RL + 1, 1'b0);

        for (int n = 0; n < 500; n++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 9) < 8) ? WB + 32'($urandom_range(0, SW - 1)) : $urandom;
            cycle(($urandom_range(0, 49) == 0), a, 1'($urandom), 1'($urandom), 4'($urandom),
                  $urandom, ($urandom_range(0, 4) == 0), 1'b0, 32'h0);
        end
        idle(RL + 2, 1'b0);
        check("sb_drain", 32'(sb.size()), 32'h0);
        running = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
